// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencing controller
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [1:0]  op,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        no_write,
    input  logic        flag_w,
    input  logic        cond_ok,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_src,
    output logic        flag_en,
    output logic        rf_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic        halted_q, halted_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pend_d    = pend_q;
        err_d     = err_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        flag_en   = 1'b0;
        rf_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;

        case (state_q)
            S_FETCH: begin
                // once issued, the request is held regardless of run
                imem_req = run | pend_q;
                if (imem_req) begin
                    if (imem_ready) begin
                        ir_en   = 1'b1;
                        pc_en   = 1'b1;
                        state_d = S_DECODE;
                    end else if (wait_q == WAIT_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                        pend_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                state_d = (op == 2'b11) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    2'b00: begin
                        flag_en = flag_w;
                        if (reg_write && !no_write) begin
                            state_d = S_WB;
                        end else begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    end
                    2'b01: state_d = S_MEM;
                    2'b10: begin
                        pc_en   = cond_ok;
                        pc_src  = 1'b1;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready) begin
                    if (mem_to_reg) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: ;
        endcase

        if (state_d != state_q) begin
            wait_d = 8'd0;
            pend_d = 1'b0;
        end
        halted_d  = (state_d == S_HALT);
        retired_d = retired_q + {31'd0, retire};

        if (rst) begin
            imem_req = 1'b0;
            ir_en    = 1'b0;
            pc_en    = 1'b0;
            pc_src   = 1'b0;
            flag_en  = 1'b0;
            rf_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign err     = err_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, reg_write, mem_write, mem_to_reg, no_write, flag_w, cond_ok;
    logic        imem_ready, dmem_ready;
    logic [1:0]  op;
    logic        imem_req, ir_en, pc_en, pc_src, flag_en, rf_we, dmem_req, dmem_we;
    logic        halted, err;
    logic [2:0]  state;
    logic [31:0] retired;
    logic [7:0]  stb;

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .run(run), .op(op),
        .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .no_write(no_write), .flag_w(flag_w), .cond_ok(cond_ok),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src),
        .flag_en(flag_en), .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .halted(halted), .err(err), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // {imem_req, ir_en, pc_en, pc_src, flag_en, rf_we, dmem_req, dmem_we}
    assign stb = {imem_req, ir_en, pc_en, pc_src, flag_en, rf_we, dmem_req, dmem_we};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs are already set at the negedge; sample, then advance to the next negedge
    task automatic cyc(input string tag, input logic [2:0] es, input logic [7:0] estb);
        #1;
        chk({tag, ".state"}, {29'd0, state}, {29'd0, es});
        chk({tag, ".stb"}, {24'd0, stb}, {24'd0, estb});
        @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic eh, input logic ee, input logic [31:0] er);
        #1;
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, ee});
        chk({tag, ".retired"}, retired, er);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_cycle.stb", {24'd0, stb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; op = 2'b00; reg_write = 1'b0; mem_write = 1'b0;
        mem_to_reg = 1'b0; no_write = 1'b0; flag_w = 1'b0; cond_ok = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        cyc("reset", 3'd0, 8'h00);
        chk_status("reset", 1'b0, 1'b0, 32'd0);
        rst = 1'b0;

        // ALU with write: 0,1,2,4,0
        op = 2'b00; reg_write = 1'b1; no_write = 1'b0; flag_w = 1'b1;
        cyc("alu_w.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("alu_w.decode", 3'd1, 8'b0000_0000);
        cyc("alu_w.exec", 3'd2, 8'b0000_1000);
        cyc("alu_w.wb", 3'd4, 8'b0000_0100);
        chk_status("alu_w.done", 1'b0, 1'b0, 32'd1);
        cyc("alu_w.idle", 3'd0, 8'h00);

        // load with dmem_ready on the third MEM cycle
        run = 1'b1; op = 2'b01; mem_to_reg = 1'b1; mem_write = 1'b0; flag_w = 1'b0;
        cyc("load.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("load.decode", 3'd1, 8'h00);
        cyc("load.exec", 3'd2, 8'h00);
        cyc("load.mem1", 3'd3, 8'b0000_0010);
        cyc("load.mem2", 3'd3, 8'b0000_0010);
        dmem_ready = 1'b1;
        cyc("load.mem3", 3'd3, 8'b0000_0010);
        dmem_ready = 1'b0;
        cyc("load.wb", 3'd4, 8'b0000_0100);
        chk_status("load.done", 1'b0, 1'b0, 32'd2);
        cyc("load.idle", 3'd0, 8'h00);

        // branch taken and not taken
        run = 1'b1; op = 2'b10; cond_ok = 1'b1;
        cyc("br1.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("br1.decode", 3'd1, 8'h00);
        cyc("br1.exec", 3'd2, 8'b0011_0000);
        chk_status("br1.done", 1'b0, 1'b0, 32'd3);
        run = 1'b1; cond_ok = 1'b0;
        cyc("br0.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("br0.decode", 3'd1, 8'h00);
        cyc("br0.exec", 3'd2, 8'b0001_0000);
        chk_status("br0.done", 1'b0, 1'b0, 32'd4);

        // ALU without write retires from EXEC
        run = 1'b1; op = 2'b00; reg_write = 1'b1; no_write = 1'b1; flag_w = 1'b0;
        cyc("alu_nw.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("alu_nw.decode", 3'd1, 8'h00);
        cyc("alu_nw.exec", 3'd2, 8'h00);
        chk_status("alu_nw.done", 1'b0, 1'b0, 32'd5);
        no_write = 1'b0;

        // store timeout after 8 MEM cycles
        run = 1'b1; op = 2'b01; mem_write = 1'b1; mem_to_reg = 1'b0; dmem_ready = 1'b0;
        cyc("st_to.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("st_to.decode", 3'd1, 8'h00);
        cyc("st_to.exec", 3'd2, 8'h00);
        for (int i = 0; i < 8; i++) cyc("st_to.mem", 3'd3, 8'b0000_0011);
        cyc("st_to.halt", 3'd5, 8'h00);
        chk_status("st_to.halt", 1'b1, 1'b1, 32'd5);
        do_reset();
        chk_status("st_to.after_rst", 1'b0, 1'b0, 32'd0);

        // store with ready exactly on the 8th MEM cycle
        run = 1'b1;
        cyc("st_ok.fetch", 3'd0, 8'b1110_0000);
        run = 1'b0;
        cyc("st_ok.decode", 3'd1, 8'h00);
        cyc("st_ok.exec", 3'd2, 8'h00);
        for (int i = 0; i < 7; i++) cyc("st_ok.mem", 3'd3, 8'b0000_0011);
        dmem_ready = 1'b1;
        cyc("st_ok.mem8", 3'd3, 8'b0000_0011);
        dmem_ready = 1'b0;
        cyc("st_ok.fetch2", 3'd0, 8'h00);
        chk_status("st_ok.done", 1'b0, 1'b0, 32'd1);

        // halt instruction: absorbing, no retire
        run = 1'b1; op = 2'b11; mem_write = 1'b0;
        cyc("halt.fetch", 3'd0, 8'b1110_0000);
        cyc("halt.decode", 3'd1, 8'h00);
        imem_ready = 1'b1; dmem_ready = 1'b1; cond_ok = 1'b1;
        for (int i = 0; i < 20; i++) cyc("halt.hold", 3'd5, 8'h00);
        chk_status("halt.hold", 1'b1, 1'b0, 32'd1);
        dmem_ready = 1'b0; cond_ok = 1'b0; run = 1'b0;
        do_reset();
        cyc("halt.after_rst", 3'd0, 8'h00);
        chk_status("halt.after_rst", 1'b0, 1'b0, 32'd0);

        // run low keeps FETCH idle
        for (int i = 0; i < 4; i++) cyc("run0", 3'd0, 8'h00);

        // pending fetch held after run drops
        run = 1'b1; imem_ready = 1'b0;
        cyc("pend.wait", 3'd0, 8'b1000_0000);
        run = 1'b0; imem_ready = 1'b1;
        op = 2'b01; mem_to_reg = 1'b1;
        cyc("pend.fetch", 3'd0, 8'b1110_0000);
        cyc("abort.decode", 3'd1, 8'h00);
        cyc("abort.exec", 3'd2, 8'h00);
        cyc("abort.mem", 3'd3, 8'b0000_0010);
        dmem_ready = 1'b1;
        do_reset();
        dmem_ready = 1'b0;
        cyc("abort.after_rst", 3'd0, 8'h00);
        chk_status("abort.after_rst", 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
